// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity codes and baud divisor helper
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clocks per oversample tick; truncating divide, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // count 0..DIV-1 and pulse tick for one clock on each wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample majority voting
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic                 tick,
  output logic                 rx_done,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = 4;
  localparam logic [SCW-1:0] SC_LAST   = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_V0     = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_V1     = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_V2     = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

  logic                 tick_int;
  logic                 rx_meta;
  logic                 rxs;
  rx_state_t            state;
  logic                 armed;
  logic [SCW-1:0]       sc;
  logic [BCW-1:0]       bit_cnt;
  logic                 vote0;
  logic                 vote1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_sh;
  logic                 frm_sh;
  logic                 bit_val;
  logic                 decide;
  logic                 par_exp;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick_int)
  );

  // two-flop synchroniser on the asynchronous line, idling high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // exported tick is delayed one clock so it lines up with the registered rx_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick <= 1'b0;
    else       tick <= tick_int;
  end

  assign bit_val = (vote0 & vote1) | (vote0 & rxs) | (vote1 & rxs);
  assign decide  = tick_int && (sc == SC_V2);
  assign par_exp = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;

  // frame FSM: sampling, shifting, error shadows and output update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      sc         <= '0;
      bit_cnt    <= '0;
      vote0      <= 1'b1;
      vote1      <= 1'b1;
      shreg      <= '0;
      par_sh     <= 1'b0;
      frm_sh     <= 1'b0;
      rx_done    <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick_int) begin
        if (state != S_IDLE) begin
          sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
          if (sc == SC_V0) vote0 <= rxs;
          if (sc == SC_V1) vote1 <= rxs;
        end
        case (state)
          S_IDLE: begin
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= S_START;
              sc    <= '0;
            end
          end
          S_START: begin
            if (decide) begin
              if (!bit_val) begin
                state   <= S_DATA;
                bit_cnt <= '0;
                par_sh  <= 1'b0;
                frm_sh  <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (decide) begin
              shreg <= {bit_val, shreg[DATA_BITS-1:1]};
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (decide) begin
              par_sh <= (bit_val != par_exp);
              state  <= S_STOP;
            end
          end
          S_STOP: begin
            if (decide) begin
              frm_sh <= frm_sh | ~bit_val;
              if (bit_cnt == STOP_LAST) begin
                data_out   <= shreg;
                parity_err <= par_sh;
                frame_err  <= frm_sh | ~bit_val;
                rx_done    <= 1'b1;
                bit_cnt    <= '0;
                state      <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
